alu_share_arbiter: RTL and testbench



---
 rtl/alu_share_arbiter_if.sv | 52 +++++
 rtl/alu_share_arbiter.sv | 117 +++++++++++
 tb/tb_alu_share_arbiter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// Bundle of the two requester ports, the shared-ALU port and the response port
// of alu_share_arbiter; slave is the arbiter side, master the surrounding logic.
interface alu_share_arbiter_if #(
    parameter int NB_DATA = 3,
    parameter int NB_SEL  = 2,
    parameter int NB_OUT  = 6
);
    logic               i_req0_valid;
    logic [NB_DATA-1:0] i_req0_data1;
    logic [NB_DATA-1:0] i_req0_data2;
    logic [NB_SEL-1:0]  i_req0_sel;
    logic               o_req0_ready;

    logic               i_req1_valid;
    logic [NB_DATA-1:0] i_req1_data1;
    logic [NB_DATA-1:0] i_req1_data2;
    logic [NB_SEL-1:0]  i_req1_sel;
    logic               o_req1_ready;

    logic [NB_DATA-1:0] o_alu_data1;
    logic [NB_DATA-1:0] o_alu_data2;
    logic [NB_SEL-1:0]  o_alu_sel;
    logic               o_alu_valid;
    logic [NB_OUT-1:0]  i_alu_data;
    logic               i_alu_overflow;

    logic               o_rsp_valid;
    logic               o_rsp_id;
    logic [NB_OUT-1:0]  o_rsp_data;
    logic               o_rsp_overflow;
    logic               i_rsp_ready;

    modport slave (
        input  i_req0_valid, i_req0_data1, i_req0_data2, i_req0_sel,
        input  i_req1_valid, i_req1_data1, i_req1_data2, i_req1_sel,
        output o_req0_ready, o_req1_ready,
        output o_alu_data1, o_alu_data2, o_alu_sel, o_alu_valid,
        input  i_alu_data, i_alu_overflow,
        output o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_overflow,
        input  i_rsp_ready
    );

    modport master (
        output i_req0_valid, i_req0_data1, i_req0_data2, i_req0_sel,
        output i_req1_valid, i_req1_data1, i_req1_data2, i_req1_sel,
        input  o_req0_ready, o_req1_ready,
        input  o_alu_data1, o_alu_data2, o_alu_sel, o_alu_valid,
        output i_alu_data, i_alu_overflow,
        input  o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_overflow,
        output i_rsp_ready
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one fixed-latency ALU between two valid/ready requesters;
// the result is returned tagged with the granted requester ID.
module alu_share_arbiter #(
    parameter int NB_DATA = 3,
    parameter int NB_SEL  = 2,
    parameter int NB_OUT  = 6,
    parameter int ALU_LAT = 1   // legal range 1..7
) (
    input  logic               clk,
    input  logic               i_rst,
    alu_share_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state_reg, state_next;
    logic               ptr_reg;
    logic [2:0]         cnt_reg;
    logic               id_reg;
    logic [NB_DATA-1:0] data1_reg, data2_reg;
    logic [NB_SEL-1:0]  sel_reg;
    logic [NB_OUT-1:0]  rsp_data_reg;
    logic               rsp_ovf_reg;

    logic [1:0]         req_valid;
    logic [NB_DATA-1:0] req_data1 [2];
    logic [NB_DATA-1:0] req_data2 [2];
    logic [NB_SEL-1:0]  req_sel   [2];
    logic [1:0]         grant;
    logic [1:0]         ready;
    logic               handshake;
    logic               hs_id;

    assign req_valid    = {bus.i_req1_valid, bus.i_req0_valid};
    assign req_data1[0] = bus.i_req0_data1;
    assign req_data1[1] = bus.i_req1_data1;
    assign req_data2[0] = bus.i_req0_data2;
    assign req_data2[1] = bus.i_req1_data2;
    assign req_sel[0]   = bus.i_req0_sel;
    assign req_sel[1]   = bus.i_req1_sel;

    // A lone valid wins outright; under contention the pointer picks the winner.
    // Gating with i_rst keeps ready low while reset is asserted mid-cycle.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_grant
            assign grant[gi] = req_valid[gi] &
                               (~req_valid[1-gi] | (ptr_reg == 1'(gi)));
            assign ready[gi] = (state_reg == IDLE) & grant[gi] & ~i_rst;
        end
    endgenerate

    assign handshake = |ready;
    assign hs_id     = ready[1];

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (handshake) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (cnt_reg == 3'd0) state_next = RESP;
            RESP:    if (bus.i_rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            ptr_reg      <= 1'b0;
            cnt_reg      <= 3'd0;
            id_reg       <= 1'b0;
            data1_reg    <= '0;
            data2_reg    <= '0;
            sel_reg      <= '0;
            rsp_data_reg <= '0;
            rsp_ovf_reg  <= 1'b0;
        end else begin
            if (handshake) begin
                data1_reg <= req_data1[hs_id];
                data2_reg <= req_data2[hs_id];
                sel_reg   <= req_sel[hs_id];
                id_reg    <= hs_id;
                ptr_reg   <= ~hs_id;
            end
            if (state_reg == ISSUE) begin
                cnt_reg <= 3'(ALU_LAT - 1);
            end else if (state_reg == WAIT && cnt_reg != 3'd0) begin
                cnt_reg <= cnt_reg - 3'd1;
            end
            // The ALU result is only guaranteed valid in the last WAIT cycle.
            if (state_reg == WAIT && cnt_reg == 3'd0) begin
                rsp_data_reg <= bus.i_alu_data;
                rsp_ovf_reg  <= bus.i_alu_overflow;
            end
        end
    end

    assign bus.o_req0_ready   = ready[0];
    assign bus.o_req1_ready   = ready[1];
    assign bus.o_alu_data1    = data1_reg;
    assign bus.o_alu_data2    = data2_reg;
    assign bus.o_alu_sel      = sel_reg;
    assign bus.o_alu_valid    = (state_reg == ISSUE);
    assign bus.o_rsp_valid    = (state_reg == RESP);
    assign bus.o_rsp_id       = id_reg;
    assign bus.o_rsp_data     = rsp_data_reg;
    assign bus.o_rsp_overflow = rsp_ovf_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: one instance with ALU_LAT=1, one with ALU_LAT=3,
// each fed by a behavioural ALU that drives its result only in the cycle it is due.
module tb_alu_share_arbiter;

    logic clk = 1'b0;
    logic i_rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    alu_share_arbiter_if #(.NB_DATA(3), .NB_SEL(2), .NB_OUT(6)) bus_a ();
    alu_share_arbiter_if #(.NB_DATA(3), .NB_SEL(2), .NB_OUT(6)) bus_b ();

    alu_share_arbiter #(.NB_DATA(3), .NB_SEL(2), .NB_OUT(6), .ALU_LAT(1)) dut_a (
        .clk(clk), .i_rst(i_rst), .bus(bus_a)
    );
    alu_share_arbiter #(.NB_DATA(3), .NB_SEL(2), .NB_OUT(6), .ALU_LAT(3)) dut_b (
        .clk(clk), .i_rst(i_rst), .bus(bus_b)
    );

    // sel 0: a*b, 1: a+b, 2: {a,b}, 3: saturate to 63 with overflow
    function automatic logic [5:0] alu_f(input logic [2:0] a, input logic [2:0] b,
                                         input logic [1:0] s);
        case (s)
            2'd0:    return 6'(a) * 6'(b);
            2'd1:    return 6'(a) + 6'(b);
            2'd2:    return {a, b};
            default: return 6'd63;
        endcase
    endfunction

    logic [7:0] pipe_a, pipe_b;
    always @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            pipe_a <= '0;
            pipe_b <= '0;
        end else begin
            pipe_a <= {pipe_a[6:0], bus_a.o_alu_valid};
            pipe_b <= {pipe_b[6:0], bus_b.o_alu_valid};
        end
    end

    assign bus_a.i_alu_data     = pipe_a[0] ? alu_f(bus_a.o_alu_data1, bus_a.o_alu_data2, bus_a.o_alu_sel) : 6'h15;
    assign bus_a.i_alu_overflow = pipe_a[0] & (bus_a.o_alu_sel == 2'd3);
    assign bus_b.i_alu_data     = pipe_b[2] ? alu_f(bus_b.o_alu_data1, bus_b.o_alu_data2, bus_b.o_alu_sel) : 6'h15;
    assign bus_b.i_alu_overflow = pipe_b[2] & (bus_b.o_alu_sel == 2'd3);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [2:0] a, input logic [2:0] b, input logic [1:0] s);
        bus_a.i_req0_valid = v;
        bus_a.i_req0_data1 = a;
        bus_a.i_req0_data2 = b;
        bus_a.i_req0_sel   = s;
    endtask

    task automatic set1(input logic v, input logic [2:0] a, input logic [2:0] b, input logic [1:0] s);
        bus_a.i_req1_valid = v;
        bus_a.i_req1_data1 = a;
        bus_a.i_req1_data2 = b;
        bus_a.i_req1_sel   = s;
    endtask

    task automatic chk_zero_a(input string tag);
        chk({tag, "_rdy0"}, bus_a.o_req0_ready, 0);
        chk({tag, "_rdy1"}, bus_a.o_req1_ready, 0);
        chk({tag, "_alu_d1"}, bus_a.o_alu_data1, 0);
        chk({tag, "_alu_d2"}, bus_a.o_alu_data2, 0);
        chk({tag, "_alu_sel"}, bus_a.o_alu_sel, 0);
        chk({tag, "_alu_valid"}, bus_a.o_alu_valid, 0);
        chk({tag, "_rsp_valid"}, bus_a.o_rsp_valid, 0);
        chk({tag, "_rsp_id"}, bus_a.o_rsp_id, 0);
        chk({tag, "_rsp_data"}, bus_a.o_rsp_data, 0);
        chk({tag, "_rsp_ovf"}, bus_a.o_rsp_overflow, 0);
    endtask

    initial begin
        set0(1'b0, 3'd0, 3'd0, 2'd0);
        set1(1'b0, 3'd0, 3'd0, 2'd0);
        bus_a.i_rsp_ready  = 1'b1;
        bus_b.i_req0_valid = 1'b0;
        bus_b.i_req0_data1 = 3'd0;
        bus_b.i_req0_data2 = 3'd0;
        bus_b.i_req0_sel   = 2'd0;
        bus_b.i_req1_valid = 1'b0;
        bus_b.i_req1_data1 = 3'd0;
        bus_b.i_req1_data2 = 3'd0;
        bus_b.i_req1_sel   = 2'd0;
        bus_b.i_rsp_ready  = 1'b1;

        // Reset values, with a pending request that must not see ready
        cyc();
        cyc();
        set0(1'b1, 3'd3, 3'd2, 2'd1);
        #1;
        chk_zero_a("rst");
        chk("rst_b_rdy0", bus_b.o_req0_ready, 0);
        chk("rst_b_rsp_valid", bus_b.o_rsp_valid, 0);
        set0(1'b0, 3'd0, 3'd0, 2'd0);
        i_rst = 1'b0;

        // Single request, latency 1: 3+2 -> 5
        cyc();
        set0(1'b1, 3'd3, 3'd2, 2'd1);
        #1;
        chk("single_T_rdy0", bus_a.o_req0_ready, 1);
        chk("single_T_rdy1", bus_a.o_req1_ready, 0);
        chk("single_T_alu_valid", bus_a.o_alu_valid, 0);
        cyc();
        set0(1'b0, 3'd0, 3'd0, 2'd0);
        #1;
        chk("single_T1_alu_valid", bus_a.o_alu_valid, 1);
        chk("single_T1_d1", bus_a.o_alu_data1, 3);
        chk("single_T1_d2", bus_a.o_alu_data2, 2);
        chk("single_T1_sel", bus_a.o_alu_sel, 1);
        chk("single_T1_rdy0", bus_a.o_req0_ready, 0);
        cyc();
        #1;
        chk("single_T2_alu_valid", bus_a.o_alu_valid, 0);
        chk("single_T2_rsp_valid", bus_a.o_rsp_valid, 0);
        cyc();
        #1;
        chk("single_T3_rsp_valid", bus_a.o_rsp_valid, 1);
        chk("single_T3_rsp_id", bus_a.o_rsp_id, 0);
        chk("single_T3_rsp_data", bus_a.o_rsp_data, 5);
        chk("single_T3_rsp_ovf", bus_a.o_rsp_overflow, 0);
        chk("single_T3_d1_held", bus_a.o_alu_data1, 3);
        cyc();

        // Solo requester 1, four back-to-back transactions: 2*3 -> 6
        set1(1'b1, 3'd2, 3'd3, 2'd0);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("solo_rdy1", bus_a.o_req1_ready, 1);
            cyc();
            #1;
            chk("solo_issue_rdy1", bus_a.o_req1_ready, 0);
            chk("solo_issue_alu_valid", bus_a.o_alu_valid, 1);
            cyc();
            cyc();
            #1;
            chk("solo_rsp_valid", bus_a.o_rsp_valid, 1);
            chk("solo_rsp_id", bus_a.o_rsp_id, 1);
            chk("solo_rsp_data", bus_a.o_rsp_data, 6);
            cyc();
        end
        set1(1'b0, 3'd0, 3'd0, 2'd0);

        // Contention: req0 5*6 -> 30, req1 {7,4} -> 60; grants alternate from id 0
        set0(1'b1, 3'd5, 3'd6, 2'd0);
        set1(1'b1, 3'd7, 3'd4, 2'd2);
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("cont_rdy0", bus_a.o_req0_ready, (k % 2 == 0) ? 1 : 0);
            chk("cont_rdy1", bus_a.o_req1_ready, (k % 2 == 1) ? 1 : 0);
            cyc();
            cyc();
            cyc();
            #1;
            chk("cont_rsp_valid", bus_a.o_rsp_valid, 1);
            chk("cont_rsp_id", bus_a.o_rsp_id, k % 2);
            chk("cont_rsp_data", bus_a.o_rsp_data, (k % 2 == 0) ? 30 : 60);
            cyc();
        end
        set0(1'b0, 3'd0, 3'd0, 2'd0);
        set1(1'b0, 3'd0, 3'd0, 2'd0);

        // Backpressure: req0 4+4 -> 8 held 5 cycles while req1 (1+6 -> 7) waits
        set0(1'b1, 3'd4, 3'd4, 2'd1);
        #1;
        chk("bp_rdy0", bus_a.o_req0_ready, 1);
        cyc();
        set0(1'b0, 3'd0, 3'd0, 2'd0);
        set1(1'b1, 3'd1, 3'd6, 2'd1);
        bus_a.i_rsp_ready = 1'b0;
        cyc();
        cyc();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_hold_rsp_valid", bus_a.o_rsp_valid, 1);
            chk("bp_hold_rsp_id", bus_a.o_rsp_id, 0);
            chk("bp_hold_rsp_data", bus_a.o_rsp_data, 8);
            chk("bp_hold_rdy0", bus_a.o_req0_ready, 0);
            chk("bp_hold_rdy1", bus_a.o_req1_ready, 0);
            cyc();
        end
        bus_a.i_rsp_ready = 1'b1;
        #1;
        chk("bp_release_rsp_valid", bus_a.o_rsp_valid, 1);
        chk("bp_release_rdy1", bus_a.o_req1_ready, 0);
        cyc();
        #1;
        chk("bp_next_rsp_valid", bus_a.o_rsp_valid, 0);
        chk("bp_next_rdy1", bus_a.o_req1_ready, 1);
        cyc();
        set1(1'b0, 3'd0, 3'd0, 2'd0);
        cyc();
        cyc();
        #1;
        chk("bp_second_rsp_id", bus_a.o_rsp_id, 1);
        chk("bp_second_rsp_data", bus_a.o_rsp_data, 7);
        cyc();

        // Reset during WAIT: req0 {2,2} granted, aborted, then regranted first
        set0(1'b1, 3'd2, 3'd2, 2'd2);
        #1;
        chk("rstw_rdy0", bus_a.o_req0_ready, 1);
        cyc();
        cyc();
        #1;
        i_rst = 1'b1;
        #1;
        chk_zero_a("rstw");
        cyc();
        set1(1'b1, 3'd3, 3'd3, 2'd1);
        i_rst = 1'b0;
        #1;
        chk("rstw_after_rdy0", bus_a.o_req0_ready, 1);
        chk("rstw_after_rdy1", bus_a.o_req1_ready, 0);
        chk("rstw_after_rsp_valid", bus_a.o_rsp_valid, 0);
        cyc();
        set0(1'b0, 3'd0, 3'd0, 2'd0);
        set1(1'b0, 3'd0, 3'd0, 2'd0);
        #1;
        chk("rstw_issue_alu_valid", bus_a.o_alu_valid, 1);
        chk("rstw_issue_d1", bus_a.o_alu_data1, 2);
        cyc();
        #1;
        chk("rstw_wait_rsp_valid", bus_a.o_rsp_valid, 0);
        cyc();
        #1;
        chk("rstw_rsp_id", bus_a.o_rsp_id, 0);
        chk("rstw_rsp_data", bus_a.o_rsp_data, 18);
        cyc();

        // Latency 3 with overflow: 63 / overflow 1, operands stable T+1..T+5
        bus_b.i_req0_valid = 1'b1;
        bus_b.i_req0_data1 = 3'd3;
        bus_b.i_req0_data2 = 3'd5;
        bus_b.i_req0_sel   = 2'd3;
        #1;
        chk("lat3_T_rdy0", bus_b.o_req0_ready, 1);
        cyc();
        bus_b.i_req0_valid = 1'b0;
        bus_b.i_req0_data1 = 3'd0;
        bus_b.i_req0_data2 = 3'd0;
        bus_b.i_req0_sel   = 2'd0;
        #1;
        chk("lat3_T1_alu_valid", bus_b.o_alu_valid, 1);
        chk("lat3_T1_d1", bus_b.o_alu_data1, 3);
        chk("lat3_T1_d2", bus_b.o_alu_data2, 5);
        chk("lat3_T1_sel", bus_b.o_alu_sel, 3);
        for (int i = 0; i < 3; i++) begin
            cyc();
            #1;
            chk("lat3_wait_alu_valid", bus_b.o_alu_valid, 0);
            chk("lat3_wait_rsp_valid", bus_b.o_rsp_valid, 0);
            chk("lat3_wait_d1", bus_b.o_alu_data1, 3);
            chk("lat3_wait_d2", bus_b.o_alu_data2, 5);
            chk("lat3_wait_sel", bus_b.o_alu_sel, 3);
        end
        cyc();
        #1;
        chk("lat3_T5_rsp_valid", bus_b.o_rsp_valid, 1);
        chk("lat3_T5_rsp_id", bus_b.o_rsp_id, 0);
        chk("lat3_T5_rsp_data", bus_b.o_rsp_data, 63);
        chk("lat3_T5_rsp_ovf", bus_b.o_rsp_overflow, 1);
        chk("lat3_T5_d1", bus_b.o_alu_data1, 3);
        chk("lat3_T5_sel", bus_b.o_alu_sel, 3);
        cyc();
        #1;
        chk("lat3_done_rsp_valid", bus_b.o_rsp_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
